// File: rtl/msk_skinny_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msk_skinny_pkg
// Purpose  : Shared constants and types for the masked Skinny-128-384 TK3
//            tweakey schedule: the PT cell permutation and its inverse, the
//            default round count, the masked cell width helper and the FSM
//            state encoding.
// Ports    : none (package)
// Config   : MSK_TK3_INV_EN (used by the importing modules; PT_INV is only
//            referenced when the inverse schedule is built)
// Revision : 1.0 - initial release
// ============================================================================
package msk_skinny_pkg;

    // Round keys issued per load for Skinny-128-384 (40 for the "+" variant).
    localparam int NROUNDS_DEFAULT = 56;

    // Number of 8-bit cells in a tweakey word.
    localparam int NCELLS = 16;

    // Forward permutation: P[i] = S[PT[i]].
    localparam int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11,
                               0,  1, 2,  3,  4,  5,  6,  7};

    // Inverse permutation: S[j] = P[PT_INV[j]], i.e. PT_INV[PT[i]] = i.
    localparam int PT_INV [16] = '{8, 9, 10, 11, 12, 13, 14, 15,
                                   2, 0,  4,  7,  6,  3,  5,  1};

    // FSM encoding, kept as plain logic constants.
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_RUN  = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    // Width of one masked cell: 8 bits, each carrying d shares.
    function automatic int cell_w(input int d);
        return 8 * d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msk_tk3_cell_step.sv
`default_nettype none
// ============================================================================
// Module   : msk_tk3_cell_step
// Purpose  : One masked TK3 cell through the LFSR3 update. Purely linear, so
//            every share is processed independently with the same function;
//            no bit of share s ever depends on another share.
// Ports    : cell_in  - masked cell, bit i at [i*D +: D], shares contiguous
//            inv      - (MSK_TK3_INV_EN only) 1 selects inverse LFSR3
//            cell_out - updated masked cell, same layout
// Config   : MSK_TK3_INV_EN adds the inv port and the inverse LFSR3.
// Revision : 1.0 - initial release
// ============================================================================
module msk_tk3_cell_step
    import msk_skinny_pkg::*;
#(
    parameter int D = 2
)
(
    input  logic [8*D-1:0] cell_in,
`ifdef MSK_TK3_INV_EN
    input  logic           inv,
`endif
    output logic [8*D-1:0] cell_out
);

    localparam int CW = cell_w(D);

    genvar s, b;
    generate
        for (s = 0; s < D; s++) begin : g_share
            logic [7:0] w_bits;
            logic [7:0] w_fwd;
            logic [7:0] w_res;

            // Gather this share's 8 bits into an ordinary byte.
            for (b = 0; b < 8; b++) begin : g_gather
                assign w_bits[b] = cell_in[b*D + s];
            end

            // Forward LFSR3: b7' = b0 ^ b6, bi' = b(i+1).
            assign w_fwd = {w_bits[0] ^ w_bits[6], w_bits[7:1]};

`ifdef MSK_TK3_INV_EN
            logic [7:0] w_inv;
            // Inverse LFSR3: b0' = b7 ^ b5, bi' = b(i-1).
            assign w_inv = {w_bits[6:0], w_bits[7] ^ w_bits[5]};
            assign w_res = inv ? w_inv : w_fwd;
`else
            assign w_res = w_fwd;
`endif

            for (b = 0; b < 8; b++) begin : g_scatter
                assign cell_out[b*D + s] = w_res[b];
            end
        end
    endgenerate

    // Layout sanity: the flat cell width must equal the helper's width.
    logic w_unused_cw;
    assign w_unused_cw = (CW == 8*D);

endmodule
`default_nettype wire

// File: rtl/msk_tk3_schedule.sv
`default_nettype none
// ============================================================================
// Module   : msk_tk3_schedule
// Purpose  : Masked TK3 tweakey schedule for masked Skinny-128-384 with D
//            shares in a bitsliced-per-bit layout. Holds the 16 masked TK3
//            cells; every consumed round key advances the state by the PT
//            cell permutation followed by LFSR3 on cells 0..7.
// Ports    : clk, rst_n   - clock, synchronous active-low reset
//            in_valid     - load request for tk3_in (accepted in IDLE/DONE)
//            in_ready     - high in IDLE or DONE
//            tk3_in       - masked TK3, cell j at [j*8*D +: 8*D],
//                           bit i of a cell at [i*D +: D]
//            out_valid    - round TK3 half valid (RUN)
//            out_ready    - round datapath consumed rtk_out
//            rtk_out      - cells 0..7 of the current state, same layout
//            rnd          - index of the round key currently on rtk_out
//            inv          - (MSK_TK3_INV_EN only) step backwards on handshake
//            done         - NROUNDS keys issued
// Config   : MSK_TK3_INV_EN adds the inv port and the inverse step.
// Revision : 1.0 - initial release
// ============================================================================
module msk_tk3_schedule
    import msk_skinny_pkg::*;
#(
    parameter int D       = 2,
    parameter int NROUNDS = NROUNDS_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [128*D-1:0]  tk3_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [64*D-1:0]   rtk_out,
    output logic [5:0]        rnd,
`ifdef MSK_TK3_INV_EN
    input  logic              inv,
`endif
    output logic              done
);

    localparam int         CW       = cell_w(D);
    localparam logic [5:0] RND_LAST = 6'(NROUNDS - 1);

    fsm_state_t           r_fsm;
    logic [128*D-1:0]     r_state;
    logic [5:0]           r_rnd;

    logic [128*D-1:0]     w_perm;      // state after forward PT
    logic [64*D-1:0]      w_step_in;   // cells 0..7 fed to the LFSR units
    logic [64*D-1:0]      w_lfsr;      // cells 0..7 after (inverse) LFSR3
    logic [128*D-1:0]     w_fwd_next;
    logic [128*D-1:0]     w_next;

    // ------------------------------------------------------------------
    // Forward permutation P[i] = S[PT[i]] (pure wiring).
    // ------------------------------------------------------------------
    genvar i;
    generate
        for (i = 0; i < NCELLS; i++) begin : g_perm
            assign w_perm[i*CW +: CW] = r_state[PT[i]*CW +: CW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // The eight LFSR units are shared by both directions: forward feeds
    // them the permuted cells, inverse feeds them the raw state cells
    // (inverse LFSR comes before the inverse permutation).
    // ------------------------------------------------------------------
`ifdef MSK_TK3_INV_EN
    assign w_step_in = inv ? r_state[64*D-1:0] : w_perm[64*D-1:0];
`else
    assign w_step_in = w_perm[64*D-1:0];
`endif

    generate
        for (i = 0; i < 8; i++) begin : g_cell
            msk_tk3_cell_step #(
                .D (D)
            ) u_step (
                .cell_in  (w_step_in[i*CW +: CW]),
`ifdef MSK_TK3_INV_EN
                .inv      (inv),
`endif
                .cell_out (w_lfsr[i*CW +: CW])
            );
        end
    endgenerate

    assign w_fwd_next = {w_perm[128*D-1:64*D], w_lfsr};

`ifdef MSK_TK3_INV_EN
    logic [128*D-1:0] w_mid;
    logic [128*D-1:0] w_inv_next;

    assign w_mid = {r_state[128*D-1:64*D], w_lfsr};

    // Undo the permutation: S'[PT[i]] = M[i]  <=>  S'[j] = M[PT_INV[j]].
    generate
        for (i = 0; i < NCELLS; i++) begin : g_iperm
            assign w_inv_next[i*CW +: CW] = w_mid[PT_INV[i]*CW +: CW];
        end
    endgenerate

    assign w_next = inv ? w_inv_next : w_fwd_next;
`else
    assign w_next = w_fwd_next;
`endif

    // ------------------------------------------------------------------
    // Control: load in IDLE/DONE, advance on each handshake in RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_rnd   <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE, ST_DONE: begin
                    if (in_valid) begin
                        r_state <= tk3_in;
                        r_rnd   <= '0;
                        r_fsm   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // out_valid is constantly high in RUN, so out_ready
                    // alone marks the handshake.
                    if (out_ready) begin
                        r_state <= w_next;
                        if (r_rnd == RND_LAST) begin
                            r_fsm <= ST_DONE;
                        end else begin
                            r_rnd <= r_rnd + 6'd1;
                        end
                    end
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_fsm == ST_IDLE) || (r_fsm == ST_DONE);
    assign out_valid = (r_fsm == ST_RUN);
    assign done      = (r_fsm == ST_DONE);
    assign rnd       = r_rnd;
    assign rtk_out   = r_state[64*D-1:0];

endmodule
`default_nettype wire
